cache_mem_arbiter: RTL

Shares the single cacheline-wide physical memory port between the instruction-cache miss path and the data-cache miss path of the pipelined core. It sits between the two L1 caches, which serve `imem_*` and `dmem_*` for the datapath, and main memory or L2. It serialises line fills and write-backs, holds one transaction open at a time, and returns each response to the requester that owns it.

---
 rtl/cache_mem_arbiter_pkg.sv | 19 +
 rtl/cache_mem_arbiter_grant_sel.sv | 31 +++
 rtl/cache_mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for cache_mem_arbiter: FSM state, owner encoding and default widths.
package arbiter_types;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int LINE_W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/cache_mem_arbiter_grant_sel.sv
// Grant policy for the I/D miss paths. Defining ARB_ROUND_ROBIN_EN alternates on ties,
// otherwise D always wins a tie so the MEM stage unblocks first.
module arb_grant_sel
    import arbiter_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_owner,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_D;
        if (i_req && !d_req) begin
            grant_owner = OWN_I;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (i_req && d_req) begin
            grant_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_owner;
    assign unused_last_owner = (last_owner == OWN_D);
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one line-wide memory port.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of fixed D priority.
module cache_mem_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int LINE_W = LINE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              d_req;
    logic              grant_valid;
    arb_owner_t        grant_owner;
    arb_owner_t        last_owner;

    assign d_req = d_read | d_write;

    arb_grant_sel u_grant_sel (
        .i_req       (i_read),
        .d_req       (d_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t last_owner_q;

    // Reset value OWN_I makes D the preferred side on the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_I;
        end else if (state_q == IDLE && grant_valid) begin
            last_owner_q <= grant_owner;
        end
    end
    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_I;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (grant_valid && grant_owner == OWN_D) begin
                    state_d = D_BUSY;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    write_d = d_write;
                end else if (grant_valid) begin
                    state_d = I_BUSY;
                    addr_d  = i_address;
                    wdata_d = '0;
                    write_d = 1'b0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pmem_read    = (state_q == I_BUSY) || (state_q == D_BUSY && !write_q);
        pmem_write   = (state_q == D_BUSY) && write_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        i_resp       = (state_q == I_BUSY) && pmem_resp;
        d_resp       = (state_q == D_BUSY) && pmem_resp;
        i_rdata      = (state_q == I_BUSY) ? pmem_rdata : '0;
        d_rdata      = (state_q == D_BUSY) ? pmem_rdata : '0;
    end

`ifndef SYNTHESIS
    // A read+write collision is served as a write-back; flag the misbehaving D-cache.
    assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write))
        else $error("cache_mem_arbiter: d_read and d_write asserted together");
`endif

endmodule
